// File: rtl/lock_code_emitter.sv
// Replays a stored lock combination as one-hot single-cycle pulses on a 4-bit bus,
// and learns a new combination from detector pulses while learn is held high.
module lock_code_emitter #(
  parameter int unsigned           CODE_LEN     = 4,
  parameter int unsigned           GAP_CYCLES   = 3,
  parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'h87
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       start,
  input  logic       learn,
  input  logic [3:0] btn_pulse,
  output logic [3:0] pulse_out,
  output logic       busy,
  output logic       done,
  output logic       learning,
  output logic       learned,
  output logic       err
);

  localparam int unsigned IdxW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned CntW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CODE_LEN - 1);
  localparam logic [CntW-1:0] GapInit = CntW'(GAP_CYCLES);

  typedef enum logic [2:0] {StIdle, StEmit, StGap, StDone, StLearn} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*CODE_LEN-1:0] code_q, code_d;
  logic [2*CODE_LEN-1:0] shadow_q, shadow_d;
  logic                  block_q, block_d;
  logic [3:0]            pulse_q, pulse_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  learning_q, learning_d;
  logic                  learned_q, learned_d;
  logic                  err_q, err_d;

  logic       commit;
  logic       learn_err;
  logic       btn_onehot;
  logic [1:0] btn_enc;

  assign btn_onehot = (btn_pulse != 4'b0000) && ((btn_pulse & (btn_pulse - 4'b0001)) == 4'b0000);

  always_comb begin
    btn_enc = 2'd0;
    unique case (btn_pulse)
      4'b0010: btn_enc = 2'd1;
      4'b0100: btn_enc = 2'd2;
      4'b1000: btn_enc = 2'd3;
      default: btn_enc = 2'd0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      block_q  <= block_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    shadow_d  = shadow_q;
    block_d   = block_q;
    commit    = 1'b0;
    learn_err = 1'b0;
    // A commit blocks LEARN re-entry until learn has been seen low.
    if (!learn) begin
      block_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (learn) begin
          if (!block_q) begin
            state_d  = StLearn;
            idx_d    = '0;
            shadow_d = '0;
          end
        end else if (start) begin
          state_d = StEmit;
          idx_d   = '0;
        end
      end
      StEmit: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else if (GAP_CYCLES == 0) begin
          idx_d = idx_q + IdxW'(1);
        end else begin
          state_d = StGap;
          cnt_d   = GapInit;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StEmit;
          idx_d   = idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      StLearn: begin
        if (!learn) begin
          // Abort wins over a coincident symbol.
          state_d = StIdle;
          idx_d   = '0;
        end else if (btn_pulse == 4'b0000) begin
          state_d = StLearn;
        end else if (btn_onehot) begin
          shadow_d[2*idx_q +: 2] = btn_enc;
          if (idx_q == LastIdx) begin
            code_d  = shadow_d;
            commit  = 1'b1;
            block_d = 1'b1;
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          learn_err = 1'b1;
          shadow_d  = '0;
          idx_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    pulse_d = 4'b0000;
    if (state_d == StEmit) begin
      pulse_d = 4'b0001 << code_q[2*idx_d +: 2];
    end
    busy_d     = (state_d == StEmit) || (state_d == StGap) || (state_d == StDone);
    done_d     = (state_d == StDone);
    learning_d = (state_d == StLearn);
    learned_d  = commit;
    err_d      = learn_err;
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      pulse_q    <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      learning_q <= 1'b0;
      learned_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      learning_q <= learning_d;
      learned_q  <= learned_d;
      err_q      <= err_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign learning  = learning_q;
  assign learned   = learned_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lock_code_emitter.sv
// Scoreboard bench: two emitters (gap 3 and gap 0); expected pulses and done pulses
// are queued with their cycle stamps at stimulus time and matched as they appear.
module tb_lock_code_emitter;

  typedef struct {
    logic [3:0] sym;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, learn_a = 1'b0;
  logic [3:0] btn_a = 4'b0;
  logic       start_b = 1'b0, learn_b = 1'b0;
  logic [3:0] btn_b = 4'b0;
  logic [3:0] pulse_a, pulse_b;
  logic       busy_a, done_a, learning_a, learned_a, err_a;
  logic       busy_b, done_b, learning_b, learned_b, err_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   lock_pos = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   dqa[$];
  int   dqb[$];

  lock_code_emitter #(.CODE_LEN(4), .GAP_CYCLES(3), .DEFAULT_CODE(8'h87)) dut_a (
    .clk_out(clk), .rst(rst), .start(start_a), .learn(learn_a), .btn_pulse(btn_a),
    .pulse_out(pulse_a), .busy(busy_a), .done(done_a), .learning(learning_a),
    .learned(learned_a), .err(err_a)
  );

  lock_code_emitter #(.CODE_LEN(4), .GAP_CYCLES(0), .DEFAULT_CODE(8'h87)) dut_b (
    .clk_out(clk), .rst(rst), .start(start_b), .learn(learn_b), .btn_pulse(btn_b),
    .pulse_out(pulse_b), .busy(busy_b), .done(done_b), .learning(learning_b),
    .learned(learned_b), .err(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] sym_of(input logic [7:0] c, input int i);
    logic [1:0] s;
    s = c[2*i +: 2];
    return 4'b0001 << s;
  endfunction

  task automatic push_exp(input bit b, input logic [7:0] code, input int s);
    exp_t e;
    int   g;
    g = b ? 0 : 3;
    for (int i = 0; i < 4; i++) begin
      e.sym = sym_of(code, i);
      e.cyc = s + i * (g + 1);
      if (b) qb.push_back(e);
      else qa.push_back(e);
    end
    if (b) dqb.push_back(s + 3 * (g + 1) + 1);
    else dqa.push_back(s + 3 * (g + 1) + 1);
  endtask

  // Returns at the negedge right after the sampling edge; cyc then equals s.
  task automatic replay(input bit b, input logic [7:0] code, output int s);
    @(negedge clk);
    if (b) start_b = 1'b1;
    else start_a = 1'b1;
    s = cyc + 1;
    push_exp(b, code, s);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input bit b);
    int n;
    n = 0;
    while (n < 60 && (b ? (busy_b || qb.size() != 0 || dqb.size() != 0)
                        : (busy_a || qa.size() != 0 || dqa.size() != 0))) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_within_budget", 32'(n < 60), 32'd1);
    check_eq("exp_queue_drained", b ? 32'(qb.size() + dqb.size()) : 32'(qa.size() + dqa.size()),
             32'd0);
  endtask

  task automatic send_btn(input logic [3:0] b);
    btn_a = b;
    @(negedge clk);
    btn_a = 4'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!rst) begin
      if (pulse_a !== 4'b0) begin
        if (qa.size() == 0) check_eq("a_unexpected_pulse", 32'(pulse_a), 32'd0);
        else begin
          e = qa.pop_front();
          check_eq("a_pulse_value", 32'(pulse_a), 32'(e.sym));
          check_eq("a_pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (done_a !== 1'b0) begin
        if (dqa.size() == 0) check_eq("a_unexpected_done", 32'(done_a), 32'd0);
        else begin
          d = dqa.pop_front();
          check_eq("a_done_cycle", 32'(cyc), 32'(d));
        end
      end
      if (pulse_b !== 4'b0) begin
        lock_pos = (pulse_b == sym_of(8'h87, lock_pos)) ? lock_pos + 1 : 0;
        if (qb.size() == 0) check_eq("b_unexpected_pulse", 32'(pulse_b), 32'd0);
        else begin
          e = qb.pop_front();
          check_eq("b_pulse_value", 32'(pulse_b), 32'(e.sym));
          check_eq("b_pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (done_b !== 1'b0) begin
        if (dqb.size() == 0) check_eq("b_unexpected_done", 32'(done_b), 32'd0);
        else begin
          d = dqb.pop_front();
          check_eq("b_done_cycle", 32'(cyc), 32'(d));
        end
      end
    end
  end

  initial begin
    int s;
    logic [3:0] seq_up[4];
    logic [3:0] seq_dn[4];
    seq_up = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq_dn = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    repeat (3) @(negedge clk);
    check_eq("rst_pulse", 32'(pulse_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_learning", 32'(learning_a), 32'd0);
    check_eq("rst_learned", 32'(learned_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Default replay with gap 3, busy window checked cycle by cycle.
    replay(1'b0, 8'h87, s);
    for (int j = 0; j < 16; j++) begin
      check_eq("t1_busy", 32'(busy_a), 32'(j <= 13));
      @(negedge clk);
    end
    wait_idle(1'b0);

    // Learn an ascending combination.
    learn_a = 1'b1;
    @(negedge clk);
    check_eq("t2_learning", 32'(learning_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_btn(seq_up[i]);
      check_eq("t2_learned", 32'(learned_a), 32'(i == 3));
      check_eq("t2_learning_mid", 32'(learning_a), 32'(i != 3));
      @(negedge clk);
    end
    check_eq("t2_learned_one_cycle", 32'(learned_a), 32'd0);
    check_eq("t2_no_reentry", 32'(learning_a), 32'd0);
    learn_a = 1'b0;
    @(negedge clk);
    replay(1'b0, 8'hE4, s);
    wait_idle(1'b0);

    // Illegal symbol restarts learning; then an abort leaves the code intact.
    learn_a = 1'b1;
    @(negedge clk);
    send_btn(4'b0001);
    @(negedge clk);
    send_btn(4'b0011);
    check_eq("t3_err", 32'(err_a), 32'd1);
    check_eq("t3_still_learning", 32'(learning_a), 32'd1);
    @(negedge clk);
    check_eq("t3_err_one_cycle", 32'(err_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_btn(seq_dn[i]);
      check_eq("t3_learned", 32'(learned_a), 32'(i == 3));
      @(negedge clk);
    end
    learn_a = 1'b0;
    @(negedge clk);
    replay(1'b0, 8'h1B, s);
    wait_idle(1'b0);
    learn_a = 1'b1;
    @(negedge clk);
    send_btn(4'b0001);
    @(negedge clk);
    send_btn(4'b0010);
    learn_a = 1'b0;
    @(negedge clk);
    check_eq("t3_abort_learning", 32'(learning_a), 32'd0);
    check_eq("t3_abort_learned", 32'(learned_a), 32'd0);
    replay(1'b0, 8'h1B, s);
    wait_idle(1'b0);

    // Start re-pulsed mid-replay must be ignored.
    replay(1'b0, 8'h1B, s);
    for (int j = 0; j < 12; j++) begin
      start_a = (cyc == s + 2) || (cyc == s + 6);
      @(negedge clk);
    end
    start_a = 1'b0;
    wait_idle(1'b0);

    // Back-to-back emitter driving a lock model.
    lock_pos = 0;
    replay(1'b1, 8'h87, s);
    wait_idle(1'b1);
    check_eq("t5_unlocked", 32'(lock_pos == 4), 32'd1);

    // Reset mid-replay restores the default combination.
    replay(1'b0, 8'h1B, s);
    repeat (5) @(negedge clk);
    qa.delete();
    dqa.delete();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_pulse", 32'(pulse_a), 32'd0);
    check_eq("t6_rst_busy", 32'(busy_a), 32'd0);
    check_eq("t6_rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    replay(1'b0, 8'h87, s);
    wait_idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
